uart_fifo: RTL and testbench

UART_FIFO -- requirements
Module: uart_fifo

---
 rtl/uart_fifo.sv | 262 ++++++++++++++++++++++++++
 tb/tb_uart_fifo.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo.sv
// Register-mapped 8N1 UART: 16x oversampled TX/RX engines, one FIFO per direction,
// sticky overrun/framing flags and a registered level interrupt.

module uart_fifo_buf #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [7:0]             data_i,
    input  logic                   pop_i,
    output logic [7:0]             head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign count_o = cnt_q;
    assign head_o  = empty_o ? 8'h00 : mem_q[rptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
            if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end
endmodule

module uart_fifo #(
    parameter int CLOCK_FREQ = 62500000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  a,
    input  logic [31:0] d,
    input  logic        we,
    input  logic        re,
    output logic [31:0] spo,
    output logic        irq,
    input  logic        rx,
    output logic        tx
);
    // state   | meaning
    // S_IDLE  | line idle; TX waits for a queued byte, RX hunts for a start edge
    // S_START | start bit (RX: confirm at its centre)
    // S_DATA  | eight data bits, LSB first
    // S_STOP  | stop bit (RX: sample at centre, then resync immediately)
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    localparam int DIV_RAW = (CLOCK_FREQ + 8 * BAUD_RATE) / (16 * BAUD_RATE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;

    logic [DW-1:0] div_q, div_d;
    logic [1:0]    sync_q, sync_d;
    state_e        tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [3:0]    tx_tcnt_q, tx_tcnt_d, rx_tcnt_q, rx_tcnt_d;
    logic [2:0]    tx_bcnt_q, tx_bcnt_d, rx_bcnt_q, rx_bcnt_d;
    logic [7:0]    tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic [1:0]    ie_q, ie_d;
    logic          ovr_q, ovr_d, ferr_q, ferr_d, irq_q, irq_d;

    logic          tick, rx_s, tx_pop, rx_push, rx_pop, tx_push, flush, tx_idle;
    logic [7:0]    txf_head, rxf_head;
    logic [CW-1:0] txf_count, rxf_count;
    logic          txf_empty, txf_full, rxf_empty, rxf_full;
    logic          unused_d;

    assign unused_d = ^d[23:0];
    assign tick     = (div_q == '0);
    assign rx_s     = sync_q[1];
    assign tx_push  = we & (a == 3'd0);
    assign rx_pop   = re & (a == 3'd0);
    assign flush    = we & (a == 3'd1) & d[31];
    assign tx_idle  = txf_empty & (tx_state_q == S_IDLE);
    assign irq      = irq_q;

    uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_txf (
        .clk(clk), .rst(rst), .flush_i(flush), .push_i(tx_push), .data_i(d[31:24]),
        .pop_i(tx_pop), .head_o(txf_head), .count_o(txf_count),
        .empty_o(txf_empty), .full_o(txf_full)
    );

    uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_rxf (
        .clk(clk), .rst(rst), .flush_i(flush), .push_i(rx_push), .data_i(rx_sh_q),
        .pop_i(rx_pop), .head_o(rxf_head), .count_o(rxf_count),
        .empty_o(rxf_empty), .full_o(rxf_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q      <= '0;
            sync_q     <= 2'b11;
            tx_state_q <= S_IDLE;
            tx_tcnt_q  <= '0;
            tx_bcnt_q  <= '0;
            tx_sh_q    <= '0;
            rx_state_q <= S_IDLE;
            rx_tcnt_q  <= '0;
            rx_bcnt_q  <= '0;
            rx_sh_q    <= '0;
            ie_q       <= '0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            div_q      <= div_d;
            sync_q     <= sync_d;
            tx_state_q <= tx_state_d;
            tx_tcnt_q  <= tx_tcnt_d;
            tx_bcnt_q  <= tx_bcnt_d;
            tx_sh_q    <= tx_sh_d;
            rx_state_q <= rx_state_d;
            rx_tcnt_q  <= rx_tcnt_d;
            rx_bcnt_q  <= rx_bcnt_d;
            rx_sh_q    <= rx_sh_d;
            ie_q       <= ie_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        div_d      = tick ? DW'(DIV - 1) : div_q - 1'b1;
        sync_d     = {sync_q[0], rx};
        tx_state_d = tx_state_q;
        tx_tcnt_d  = tx_tcnt_q;
        tx_bcnt_d  = tx_bcnt_q;
        tx_sh_d    = tx_sh_q;
        rx_state_d = rx_state_q;
        rx_tcnt_d  = rx_tcnt_q;
        rx_bcnt_d  = rx_bcnt_q;
        rx_sh_d    = rx_sh_q;
        if (tick) begin
            case (tx_state_q)
                S_IDLE: if (tx_pop) begin
                    tx_sh_d    = txf_head;
                    tx_tcnt_d  = 4'd15;
                    tx_state_d = S_START;
                end
                S_START: if (tx_tcnt_q == 4'd0) begin
                    tx_tcnt_d  = 4'd15;
                    tx_bcnt_d  = 3'd7;
                    tx_state_d = S_DATA;
                end else tx_tcnt_d = tx_tcnt_q - 4'd1;
                S_DATA: if (tx_tcnt_q == 4'd0) begin
                    tx_tcnt_d = 4'd15;
                    if (tx_bcnt_q == 3'd0) tx_state_d = S_STOP;
                    else begin
                        tx_bcnt_d = tx_bcnt_q - 3'd1;
                        tx_sh_d   = {1'b0, tx_sh_q[7:1]};
                    end
                end else tx_tcnt_d = tx_tcnt_q - 4'd1;
                S_STOP: if (tx_tcnt_q == 4'd0) begin
                    // Chain straight into the next start bit when more data is queued.
                    if (tx_pop) begin
                        tx_sh_d    = txf_head;
                        tx_tcnt_d  = 4'd15;
                        tx_state_d = S_START;
                    end else tx_state_d = S_IDLE;
                end else tx_tcnt_d = tx_tcnt_q - 4'd1;
                default: tx_state_d = S_IDLE;
            endcase
            case (rx_state_q)
                S_IDLE: if (!rx_s) begin
                    rx_tcnt_d  = 4'd7;
                    rx_state_d = S_START;
                end
                S_START: if (rx_tcnt_q == 4'd0) begin
                    if (rx_s) rx_state_d = S_IDLE;
                    else begin
                        rx_tcnt_d  = 4'd15;
                        rx_bcnt_d  = 3'd7;
                        rx_state_d = S_DATA;
                    end
                end else rx_tcnt_d = rx_tcnt_q - 4'd1;
                S_DATA: if (rx_tcnt_q == 4'd0) begin
                    rx_sh_d   = {rx_s, rx_sh_q[7:1]};
                    rx_tcnt_d = 4'd15;
                    if (rx_bcnt_q == 3'd0) rx_state_d = S_STOP;
                    else rx_bcnt_d = rx_bcnt_q - 3'd1;
                end else rx_tcnt_d = rx_tcnt_q - 4'd1;
                S_STOP: if (rx_tcnt_q == 4'd0) rx_state_d = S_IDLE;
                        else rx_tcnt_d = rx_tcnt_q - 4'd1;
                default: rx_state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        case (tx_state_q)
            S_START: tx = 1'b0;
            S_DATA:  tx = tx_sh_q[0];
            default: tx = 1'b1;
        endcase
        tx_pop  = tick & ~txf_empty & ~flush &
                  ((tx_state_q == S_IDLE) | ((tx_state_q == S_STOP) & (tx_tcnt_q == 4'd0)));
        rx_push = tick & (rx_state_q == S_STOP) & (rx_tcnt_q == 4'd0);
    end

    // Sticky flags: a set in the same clock as a clear wins.
    always_comb begin
        ie_d   = (we && a == 3'd2) ? d[25:24] : ie_q;
        ovr_d  = (ovr_q  & ~(we & (a == 3'd1) & d[24])) | (rx_push & rxf_full);
        ferr_d = (ferr_q & ~(we & (a == 3'd1) & d[25])) | (rx_push & ~rx_s);
        irq_d  = (ie_q[0] & ~rxf_empty) | (ie_q[1] & tx_idle);
    end

    always_comb begin
        spo = '0;
        case (a)
            3'd0: spo[31:24] = rxf_head;
            3'd1: spo[30:24] = {ferr_q, ovr_q, tx_idle, txf_full, txf_empty, rxf_full, ~rxf_empty};
            3'd2: spo[25:24] = ie_q;
            3'd3: begin
                spo[31:24] = 8'(rxf_count);
                spo[23:16] = 8'(txf_count);
            end
            default: spo = '0;
        endcase
    end
endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: register vector table plus hand-built serial sequences
// (DIV = 4, so one bit is 64 clocks; FIFO depth 4).

module tb_uart_fifo;
    localparam int CLOCK_FREQ = 7372800;
    localparam int BAUD_RATE  = 115200;
    localparam int DEPTH      = 4;
    localparam int BITC       = 64;

    typedef struct {
        logic        we;
        logic [2:0]  wa;
        logic [31:0] wd;
        logic [2:0]  ra;
        logic [31:0] exp;
        logic        exp_irq;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  a = 3'd0;
    logic [31:0] d = 32'h0;
    logic        we = 1'b0, re = 1'b0;
    logic [31:0] spo;
    logic        irq, tx, rx;
    logic        rx_drv = 1'b1, loop = 1'b0;
    int          nvec = 0, nfail = 0, cyc = 0;

    assign rx = loop ? tx : rx_drv;

    uart_fifo #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .re(re),
        .spo(spo), .irq(irq), .rx(rx), .tx(tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] addr, output logic [31:0] v);
        a = addr;
        #1;
        v = spo;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        a = addr; d = data; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk);
        a = 3'd0; re = 1'b1;
        @(negedge clk);
        re = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stopb);
        rx_drv = 1'b0;
        repeat (BITC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (BITC) @(negedge clk);
        end
        rx_drv = stopb;
        repeat (BITC) @(negedge clk);
        rx_drv = 1'b1;
        repeat (32) @(negedge clk);
    endtask

    task automatic wait_fall(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            cyc_wait(1);
            if (!tx) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[12];
        logic [31:0] v;
        logic        ok;
        logic [7:0]  got;
        logic [9:0]  fr[3];
        logic [7:0]  b3[3];
        logic [7:0]  ovb[5];
        int          lows, f_cyc;

        vecs[0]  = '{1'b0, 3'd0, 32'h00000000, 3'd0, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 3'd0, 32'h00000000, 3'd1, 32'h14000000, 1'b0};
        vecs[2]  = '{1'b0, 3'd0, 32'h00000000, 3'd2, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b0, 3'd0, 32'h00000000, 3'd3, 32'h00000000, 1'b0};
        vecs[4]  = '{1'b1, 3'd2, 32'hFF000000, 3'd2, 32'h03000000, 1'b1};
        vecs[5]  = '{1'b1, 3'd2, 32'h01000000, 3'd2, 32'h01000000, 1'b0};
        vecs[6]  = '{1'b1, 3'd3, 32'hFFFFFFFF, 3'd3, 32'h00000000, 1'b0};
        vecs[7]  = '{1'b0, 3'd0, 32'h00000000, 3'd4, 32'h00000000, 1'b0};
        vecs[8]  = '{1'b0, 3'd0, 32'h00000000, 3'd7, 32'h00000000, 1'b0};
        vecs[9]  = '{1'b1, 3'd1, 32'h83000000, 3'd1, 32'h14000000, 1'b0};
        vecs[10] = '{1'b1, 3'd2, 32'h02000000, 3'd2, 32'h02000000, 1'b1};
        vecs[11] = '{1'b1, 3'd2, 32'h00000000, 3'd2, 32'h00000000, 1'b0};
        b3[0] = 8'h11; b3[1] = 8'h22; b3[2] = 8'h33;
        ovb[0] = 8'hC3; ovb[1] = 8'h3C; ovb[2] = 8'h81; ovb[3] = 8'h7E; ovb[4] = 8'hFF;

        // reset state
        repeat (3) @(negedge clk);
        check1("rst_tx", tx, 1'b1);
        check1("rst_irq", irq, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].we) wr(vecs[i].wa, vecs[i].wd);
            cyc_wait(1);
            rd(vecs[i].ra, v);
            check($sformatf("vec%0d_spo", i), v, vecs[i].exp);
            check1($sformatf("vec%0d_irq", i), irq, vecs[i].exp_irq);
        end

        // single frame 0xA5
        wr(3'd0, 32'hA5000000);
        wait_fall(ok);
        check1("a5_start_seen", ok, 1'b1);
        f_cyc = cyc;
        lows = 0;
        for (int i = 0; i < 64; i++) begin
            if (!tx) lows++;
            cyc_wait(1);
        end
        check("a5_start_len", lows, 64);
        check1("a5_after_start", tx, 1'b1);
        got = 8'h00;
        for (int j = 0; j < 8; j++) begin
            cyc_wait(j == 0 ? 32 : 64);
            got[j] = tx;
            if (j == 3) begin
                rd(3'd1, v);
                check("a5_busy_status", v, 32'h04000000);
            end
        end
        check("a5_data", {24'h0, got}, 32'h000000A5);
        cyc_wait(64);
        check1("a5_stop", tx, 1'b1);
        cyc_wait(40);
        rd(3'd1, v);
        check("a5_idle_status", v, 32'h14000000);

        // three back-to-back frames, writes placed just after a tick edge
        for (int i = 0; i < 8 && ((cyc - f_cyc) % 4) != 0; i++) cyc_wait(1);
        a = 3'd0; d = 32'h11000000; we = 1'b1;
        cyc_wait(1);
        d = 32'h22000000;
        cyc_wait(1);
        d = 32'h33000000;
        cyc_wait(1);
        we = 1'b0;
        rd(3'd3, v);
        check("b2b_txcnt3", v, 32'h00030000);
        cyc_wait(1);
        check1("b2b_start_fall", tx, 1'b0);
        for (int j = 0; j < 30; j++) begin
            cyc_wait(j == 0 ? 32 : 64);
            fr[j / 10][j % 10] = tx;
            if (j == 5) begin
                rd(3'd3, v);
                check("b2b_txcnt2", v, 32'h00020000);
            end
            if (j == 15) begin
                rd(3'd3, v);
                check("b2b_txcnt1", v, 32'h00010000);
            end
            if (j == 25) begin
                rd(3'd3, v);
                check("b2b_txcnt0", v, 32'h00000000);
            end
        end
        for (int k = 0; k < 3; k++)
            check($sformatf("b2b_frame%0d", k), {22'h0, fr[k]}, {22'h0, 1'b1, b3[k], 1'b0});
        cyc_wait(40);
        rd(3'd1, v);
        check("b2b_idle_status", v, 32'h14000000);

        // loopback 0x5A with RX interrupt
        loop = 1'b1;
        wr(3'd2, 32'h01000000);
        wr(3'd0, 32'h5A000000);
        a = 3'd1;
        ok = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            cyc_wait(1);
            if (spo[24]) begin
                ok = 1'b1;
                break;
            end
        end
        check1("loop_rx_seen", ok, 1'b1);
        check1("irq_latency", irq, 1'b0);
        cyc_wait(1);
        check1("irq_set", irq, 1'b1);
        rd(3'd0, v);
        check("loop_byte", v, 32'h5A000000);
        pop();
        check1("irq_hold", irq, 1'b1);
        rd(3'd3, v);
        check("loop_cnt_after_pop", v, 32'h00000000);
        rd(3'd0, v);
        check("loop_empty_rd", v, 32'h00000000);
        cyc_wait(1);
        check1("irq_clear", irq, 1'b0);
        wr(3'd2, 32'h00000000);
        loop = 1'b0;
        cyc_wait(100);

        // overrun: DEPTH+1 frames without pops
        for (int k = 0; k < 5; k++) send_rx(ovb[k], 1'b1);
        rd(3'd1, v);
        check("ovr_status", v, 32'h37000000);
        rd(3'd3, v);
        check("ovr_rxcnt", v, 32'h04000000);
        wr(3'd1, 32'h01000000);
        rd(3'd1, v);
        check("ovr_cleared", v, 32'h17000000);
        for (int k = 0; k < 4; k++) begin
            rd(3'd0, v);
            check($sformatf("ovr_byte%0d", k), v, {ovb[k], 24'h0});
            pop();
        end
        rd(3'd3, v);
        check("ovr_drained", v, 32'h00000000);

        // false start, then a framing error
        rx_drv = 1'b0;
        repeat (16) @(negedge clk);
        rx_drv = 1'b1;
        cyc_wait(600);
        rd(3'd3, v);
        check("false_start_cnt", v, 32'h00000000);
        send_rx(8'h96, 1'b0);
        cyc_wait(100);
        rd(3'd1, v);
        check("ferr_status", v, 32'h55000000);
        rd(3'd0, v);
        check("ferr_byte", v, 32'h96000000);
        wr(3'd1, 32'h02000000);
        rd(3'd1, v);
        check("ferr_cleared", v, 32'h15000000);
        pop();

        // flush drops queued bytes, the frame in flight completes
        wr(3'd0, 32'h11000000);
        wr(3'd0, 32'h22000000);
        wr(3'd0, 32'h33000000);
        wr(3'd1, 32'h80000000);
        rd(3'd3, v);
        check("flush_cnt", v, 32'h00000000);
        cyc_wait(1000);
        rd(3'd1, v);
        check("flush_one_frame", v, 32'h14000000);

        // reset in the middle of a frame
        loop = 1'b1;
        wr(3'd0, 32'h00000000);
        wait_fall(ok);
        check1("rst_frame_started", ok, 1'b1);
        cyc_wait(100);
        check1("rst_pre_tx_low", tx, 1'b0);
        rst = 1'b1;
        #1;
        check1("rst_tx_async", tx, 1'b1);
        check1("rst_irq_async", irq, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc_wait(1000);
        rd(3'd3, v);
        check("rst_no_partial", v, 32'h00000000);
        rd(3'd1, v);
        check("rst_status", v, 32'h14000000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
